// File: rtl/jpeg_dqt_multi.sv
// JPEG dequantiser: loads quantisation tables from raw DQT segment bytes, multiplies
// each zigzag-ordered coefficient by its table entry, saturates and emits it in raster order.
module jpeg_dqt_multi #(
    parameter int NUM_TABLES = 4,
    parameter int COEF_W     = 16,
    parameter int OUT_W      = 16,
    parameter int ID_W       = 32,
    parameter int SATURATE   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              img_start_i,
    input  logic [1:0]        img_dqt_table_y_i,
    input  logic [1:0]        img_dqt_table_cb_i,
    input  logic [1:0]        img_dqt_table_cr_i,
    input  logic              cfg_valid_i,
    input  logic [7:0]        cfg_data_i,
    input  logic              cfg_last_i,
    output logic              cfg_accept_o,
    output logic              cfg_err_o,
    input  logic              inport_valid_i,
    input  logic [COEF_W-1:0] inport_data_i,
    input  logic [5:0]        inport_idx_i,
    input  logic [ID_W-1:0]   inport_id_i,
    input  logic              inport_eob_i,
    output logic              inport_ready_o,
    output logic              outport_valid_o,
    output logic [OUT_W-1:0]  outport_data_o,
    output logic [5:0]        outport_idx_o,
    output logic [ID_W-1:0]   outport_id_o,
    output logic              outport_eob_o,
    input  logic              outport_accept_i
);
    localparam int AW = $clog2(NUM_TABLES * 64);
    localparam int PW = COEF_W + 17;
    localparam logic signed [PW-1:0] MAXV = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [5:0] DEZIG [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    typedef enum logic [1:0] {HDR, HI, LO} cfg_state_t;

    cfg_state_t state, state_nxt;
    logic [3:0] pq, tq;
    logic [5:0] cnt;
    logic [7:0] hi;
    logic       seg_bad, hdr_bad, tbl_we;
    logic [15:0] mem [NUM_TABLES*64];
    logic [15:0] entry;

    always_comb begin
        state_nxt = state;
        tbl_we    = 1'b0;
        hdr_bad   = (cfg_data_i[3:0] >= 4'(NUM_TABLES)) || (cfg_data_i[7:4] > 4'd1);
        if (cfg_valid_i) begin
            case (state)
                HDR: state_nxt = (cfg_data_i[7:4] == 4'd1) ? HI : LO;
                HI:  state_nxt = LO;
                LO: begin
                    tbl_we    = !seg_bad;
                    state_nxt = (cnt == 6'd63) ? HDR : ((pq == 4'd1) ? HI : LO);
                end
                default: state_nxt = HDR;
            endcase
            if (cfg_last_i) state_nxt = HDR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= HDR;
            pq        <= '0;
            tq        <= '0;
            cnt       <= '0;
            hi        <= '0;
            seg_bad   <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cfg_valid_i) begin
                case (state)
                    HDR: begin
                        pq      <= cfg_data_i[7:4];
                        tq      <= cfg_data_i[3:0];
                        cnt     <= '0;
                        seg_bad <= hdr_bad;
                        if (hdr_bad) cfg_err_o <= 1'b1;
                    end
                    HI:      hi  <= cfg_data_i;
                    LO:      cnt <= cnt + 6'd1;
                    default: ;
                endcase
            end
        end
    end

    assign cfg_accept_o = 1'b1;

    logic       en, fire;
    logic [1:0] sel;

    assign en             = !outport_valid_o || outport_accept_i;
    // A table write owns the RAM port, so the coefficient read waits that cycle.
    assign inport_ready_o = rst_ni && en && !img_start_i && !(cfg_valid_i && state == LO);
    assign fire           = inport_valid_i && inport_ready_o;

    always_comb begin
        case (inport_id_i[ID_W-1:ID_W-2])
            2'd0:    sel = img_dqt_table_y_i;
            2'd1:    sel = img_dqt_table_cb_i;
            2'd2:    sel = img_dqt_table_cr_i;
            default: sel = 2'd0;
        endcase
        if ({1'b0, sel} >= 3'(NUM_TABLES)) sel = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (tbl_we) mem[AW'({tq, cnt})] <= (pq == 4'd1) ? {hi, cfg_data_i} : {8'h00, cfg_data_i};
        if (fire) entry <= mem[AW'({sel, inport_idx_i})];
    end

    logic                     s1_vld, s1_eob;
    logic signed [COEF_W-1:0] s1_data;
    logic [5:0]               s1_idx;
    logic [ID_W-1:0]          s1_id;
    logic signed [PW-1:0]     prod;
    logic [OUT_W-1:0]         sat_val;

    assign prod = PW'(s1_data) * PW'($signed({1'b0, entry}));

    always_comb begin
        if (SATURATE != 0 && prod > MAXV)      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        else if (SATURATE != 0 && prod < MINV) sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else                                   sat_val = prod[OUT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld          <= 1'b0;
            s1_data         <= '0;
            s1_idx          <= '0;
            s1_id           <= '0;
            s1_eob          <= 1'b0;
            outport_valid_o <= 1'b0;
            outport_data_o  <= '0;
            outport_idx_o   <= '0;
            outport_id_o    <= '0;
            outport_eob_o   <= 1'b0;
        end else if (img_start_i) begin
            s1_vld          <= 1'b0;
            outport_valid_o <= 1'b0;
        end else if (en) begin
            s1_vld <= fire;
            if (fire) begin
                s1_data <= inport_data_i;
                s1_idx  <= inport_idx_i;
                s1_id   <= inport_id_i;
                s1_eob  <= inport_eob_i;
            end
            outport_valid_o <= s1_vld;
            if (s1_vld) begin
                outport_data_o <= sat_val;
                outport_idx_o  <= DEZIG[s1_idx];
                outport_id_o   <= s1_id;
                outport_eob_o  <= s1_eob;
            end
        end
    end
endmodule
